ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Carries the decoded control word from the ID stage through the ID/EX, EX/MEM and MEM/WB pipeline registers. It is the consuming end of the opcode decoder's control bundle. It detects load-use hazards, inserts bubbles, honours flushes, suppresses writes to register 0, and counts stall cycles. It sits between the decoder and the EX/MEM/WB datapath muxes, and it drives the PC and IF/ID write-enable through `stall_o`.

## Interface
- `REG_W`, 5: register-index width.
- `ALUOP_W`, 3: ALUOp width.
- `CNT_W`, 16: stall-counter width.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_RegDst`, `id_MemRead`, `id_MemtoReg`, `id_MemWrite`, `id_ALUSrc`, `id_RegWrite`  in  1 each  decoder control bits for the instruction in ID.
- `id_ALUOp`  in  ALUOP_W  decoder ALU operation.
- `id_rs`, `id_rt`, `id_rd`  in  REG_W each  register fields of the instruction in ID.
- `flush_i`  in  1  discard the instruction in ID (bubble into ID/EX).
- `ex_ALUOp`  out  ALUOP_W;  `ex_ALUSrc`, `ex_RegDst`  out  1  EX-stage controls.
- `ex_dst`  out  REG_W  EX destination: `ex_RegDst ? rd : rt` (combinational from the ID/EX register).
- `mem_MemRead`, `mem_MemWrite`  out  1;  `mem_dst`  out  REG_W  MEM-stage controls.
- `wb_RegWrite`, `wb_MemtoReg`  out  1;  `wb_dst`  out  REG_W  WB-stage controls.
- `stall_o`  out  1  combinational; high means hold the PC and IF/ID.
- `stall_cnt`  out  CNT_W  number of stall cycles since reset, saturating.

## Operation
- The ID/EX register holds RegDst, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite, rt and rd.
- The EX/MEM register holds MemRead, MemWrite, MemtoReg, RegWrite and dst.
- The MEM/WB register holds MemtoReg, RegWrite and dst.
- Bubble: the all-zero control word, which equals the decoder's NOP (opcode 0) output. Its rt, rd and dst fields are 0.
- Rt-use term: `uses_rt = id_RegDst | id_MemWrite`. This covers R-type sources and the store-data source.
- Hazard term: `hz = ID/EX.MemRead & (ex_dst != 0) & ((ex_dst == id_rs) | (uses_rt & (ex_dst == id_rt)))`.
- Stall output: `stall_o = hz & ~flush_i`.
- ID/EX next value:
  - bubble if `rst`, `flush_i` or `hz`;
  - otherwise the `id_*` inputs.
- EX/MEM next value:
  - all zeros on `rst`;
  - otherwise the ID/EX controls, with dst = `ex_dst`;
  - RegWrite is forced to 0 when `ex_dst == 0`, so register 0 is never written.
- MEM/WB next value: all zeros on `rst`; otherwise the EX/MEM contents.
- Stall counter:
  - clears on `rst`;
  - increments by 1 on each cycle with `stall_o = 1`;
  - holds at `2^CNT_W - 1` once reached (no wrap).
- Flush and hazard in the same cycle:
  - flush wins, so one bubble is inserted and `stall_o` is 0;
  - the counter does not increment.
- Reset mid-operation: all three stage registers are zeroed on that edge. Any in-flight stores or register writes are cancelled.
- Hazard states: there is no explicit FSM. After one bubble, the LW has moved to EX/MEM, so `hz` drops by itself and the ID instruction proceeds on the next edge.

## Timing
- All stage registers and the counter update on the rising edge of `clk`. `rst` is sampled on that same edge.
- Reset value of every registered output is 0. This covers `ex_*`, `mem_*`, `wb_*` and `stall_cnt`.
- `ex_dst` and `stall_o` are combinational, so each is 0 while the stage registers hold their reset value.
- Latency per stage:
  - an ID control word appears on the `ex_*` outputs 1 cycle later;
  - on the `mem_*` outputs 2 cycles later;
  - on the `wb_*` outputs 3 cycles later.
- A load-use dependency costs exactly 1 stall cycle. `stall_o` is high in the cycle the dependent instruction sits in ID with the LW in EX.
- `stall_o` depends combinationally on the `id_*` inputs and `flush_i`; it has no registered delay.

## Test plan
- LW (MemRead=1, ALUSrc=1, RegWrite=1, rt=5), then R-type ADD with rs=5:
  - `stall_o` is 1 for exactly 1 cycle, with `ex_*` equal to the bubble in the next cycle;
  - ADD reaches EX one cycle later;
  - `stall_cnt` reads 1.
- LW with rt=0, then ADD with rs=0: no stall; the LW's `mem_dst` is 0 and its `wb_RegWrite` is 0.
- LW rt=7, then SW with rt=7 (MemWrite=1) → stall. LW rt=7, then ADDI with rt=7 (uses_rt=0) and rs≠7 → no stall.
- Hazard pair as in the first scenario with `flush_i=1` in the hazard cycle:
  - `stall_o` is 0 and a bubble enters EX;
  - `stall_cnt` is unchanged.
- Issue SW, then assert `rst` while the SW sits in EX/MEM: the next edge shows `mem_MemWrite=0` and all `wb_*` outputs at 0.
- With `CNT_W=4`, force 20 hazard cycles: `stall_cnt` saturates at 15 and holds there.

Source files
------------

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe
// Purpose  : ID/EX, EX/MEM and MEM/WB control registers with load-use stall,
//            flush bubbles, register-0 write suppression and a stall counter.
// Revision : 1.0
// ============================================================================
module ctrl_pipe #(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_RegDst,
    input  logic               id_MemRead,
    input  logic               id_MemtoReg,
    input  logic               id_MemWrite,
    input  logic               id_ALUSrc,
    input  logic               id_RegWrite,
    input  logic [ALUOP_W-1:0] id_ALUOp,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               flush_i,
    output logic [ALUOP_W-1:0] ex_ALUOp,
    output logic               ex_ALUSrc,
    output logic               ex_RegDst,
    output logic [REG_W-1:0]   ex_dst,
    output logic               mem_MemRead,
    output logic               mem_MemWrite,
    output logic [REG_W-1:0]   mem_dst,
    output logic               wb_RegWrite,
    output logic               wb_MemtoReg,
    output logic [REG_W-1:0]   wb_dst,
    output logic               stall_o,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [REG_W-1:0] c_reg0    = '0;

    // ID/EX
    logic               r_ex_regdst;
    logic               r_ex_memread;
    logic               r_ex_memtoreg;
    logic               r_ex_memwrite;
    logic               r_ex_alusrc;
    logic               r_ex_regwrite;
    logic [ALUOP_W-1:0] r_ex_aluop;
    logic [REG_W-1:0]   r_ex_rt;
    logic [REG_W-1:0]   r_ex_rd;

    // EX/MEM
    logic               r_mem_memread;
    logic               r_mem_memwrite;
    logic               r_mem_memtoreg;
    logic               r_mem_regwrite;
    logic [REG_W-1:0]   r_mem_dst;

    // MEM/WB
    logic               r_wb_memtoreg;
    logic               r_wb_regwrite;
    logic [REG_W-1:0]   r_wb_dst;

    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_uses_rt;
    logic               w_hz;
    logic               w_bubble;
    logic [REG_W-1:0]   w_ex_dst;

    assign w_ex_dst  = r_ex_regdst ? r_ex_rd : r_ex_rt;
    assign w_uses_rt = id_RegDst | id_MemWrite;
    assign w_hz      = r_ex_memread & (w_ex_dst != c_reg0) &
                       ((w_ex_dst == id_rs) | (w_uses_rt & (w_ex_dst == id_rt)));
    assign w_bubble  = rst | flush_i | w_hz;

    always_ff @(posedge clk) begin
        if (w_bubble) begin
            r_ex_regdst   <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_memtoreg <= 1'b0;
            r_ex_memwrite <= 1'b0;
            r_ex_alusrc   <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_aluop    <= '0;
            r_ex_rt       <= '0;
            r_ex_rd       <= '0;
        end else begin
            r_ex_regdst   <= id_RegDst;
            r_ex_memread  <= id_MemRead;
            r_ex_memtoreg <= id_MemtoReg;
            r_ex_memwrite <= id_MemWrite;
            r_ex_alusrc   <= id_ALUSrc;
            r_ex_regwrite <= id_RegWrite;
            r_ex_aluop    <= id_ALUOp;
            r_ex_rt       <= id_rt;
            r_ex_rd       <= id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_dst      <= '0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_regwrite  <= 1'b0;
            r_wb_dst       <= '0;
        end else begin
            r_mem_memread  <= r_ex_memread;
            r_mem_memwrite <= r_ex_memwrite;
            r_mem_memtoreg <= r_ex_memtoreg;
            // Register 0 is hardwired; never let a write to it reach WB
            r_mem_regwrite <= r_ex_regwrite & (w_ex_dst != c_reg0);
            r_mem_dst      <= w_ex_dst;
            r_wb_memtoreg  <= r_mem_memtoreg;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_dst       <= r_mem_dst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stall_o && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_o      = w_hz & ~flush_i;
    assign stall_cnt    = r_stall_cnt;
    assign ex_ALUOp     = r_ex_aluop;
    assign ex_ALUSrc    = r_ex_alusrc;
    assign ex_RegDst    = r_ex_regdst;
    assign ex_dst       = w_ex_dst;
    assign mem_MemRead  = r_mem_memread;
    assign mem_MemWrite = r_mem_memwrite;
    assign mem_dst      = r_mem_dst;
    assign wb_RegWrite  = r_wb_regwrite;
    assign wb_MemtoReg  = r_wb_memtoreg;
    assign wb_dst       = r_wb_dst;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe
// Purpose  : Directed vector bench for ctrl_pipe (CNT_W=4 to reach saturation).
// Revision : 1.0
// ============================================================================
module tb_ctrl_pipe;

    localparam int REG_W   = 5;
    localparam int ALUOP_W = 3;
    localparam int CNT_W   = 4;
    localparam int NV      = 20;

    // {RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp[2:0]}
    localparam logic [8:0] c_nop  = 9'b0_0_0_0_0_0_000;
    localparam logic [8:0] c_lw   = 9'b0_1_1_0_1_1_000;
    localparam logic [8:0] c_add  = 9'b1_0_0_0_0_1_010;
    localparam logic [8:0] c_sw   = 9'b0_0_0_1_1_0_000;
    localparam logic [8:0] c_addi = 9'b0_0_0_0_1_1_000;

    logic               clk;
    logic               rst;
    logic               id_RegDst, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite;
    logic [ALUOP_W-1:0] id_ALUOp;
    logic [REG_W-1:0]   id_rs, id_rt, id_rd;
    logic               flush_i;
    logic [ALUOP_W-1:0] ex_ALUOp;
    logic               ex_ALUSrc, ex_RegDst;
    logic [REG_W-1:0]   ex_dst;
    logic               mem_MemRead, mem_MemWrite;
    logic [REG_W-1:0]   mem_dst;
    logic               wb_RegWrite, wb_MemtoReg;
    logic [REG_W-1:0]   wb_dst;
    logic               stall_o;
    logic [CNT_W-1:0]   stall_cnt;

    int total;
    int bad;

    ctrl_pipe #(.REG_W(REG_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_RegDst(id_RegDst), .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg),
        .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite),
        .id_ALUOp(id_ALUOp), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush_i(flush_i),
        .ex_ALUOp(ex_ALUOp), .ex_ALUSrc(ex_ALUSrc), .ex_RegDst(ex_RegDst), .ex_dst(ex_dst),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_dst(mem_dst),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_dst(wb_dst),
        .stall_o(stall_o), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic [8:0]       ctl;
        logic [REG_W-1:0] rs, rt, rd;
        logic             flush;
        logic             e_stall;
        logic [2:0]       e_aluop;
        logic             e_alusrc, e_regdst;
        logic [REG_W-1:0] e_exdst;
        logic             e_mrd, e_mwr;
        logic [REG_W-1:0] e_mdst;
        logic             e_wrw, e_wmtr;
        logic [REG_W-1:0] e_wdst;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    vec_t tv [NV];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [8:0] ctl, input logic [REG_W-1:0] rs,
                         input logic [REG_W-1:0] rt, input logic [REG_W-1:0] rd, input logic fl);
        rst         = r;
        id_RegDst   = ctl[8];
        id_MemRead  = ctl[7];
        id_MemtoReg = ctl[6];
        id_MemWrite = ctl[5];
        id_ALUSrc   = ctl[4];
        id_RegWrite = ctl[3];
        id_ALUOp    = ctl[2:0];
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        flush_i     = fl;
    endtask

    task automatic chk_regs(input int idx, input vec_t v);
        chk("ex_ALUOp",     idx, 32'(ex_ALUOp),     32'(v.e_aluop));
        chk("ex_ALUSrc",    idx, 32'(ex_ALUSrc),    32'(v.e_alusrc));
        chk("ex_RegDst",    idx, 32'(ex_RegDst),    32'(v.e_regdst));
        chk("ex_dst",       idx, 32'(ex_dst),       32'(v.e_exdst));
        chk("mem_MemRead",  idx, 32'(mem_MemRead),  32'(v.e_mrd));
        chk("mem_MemWrite", idx, 32'(mem_MemWrite), 32'(v.e_mwr));
        chk("mem_dst",      idx, 32'(mem_dst),      32'(v.e_mdst));
        chk("wb_RegWrite",  idx, 32'(wb_RegWrite),  32'(v.e_wrw));
        chk("wb_MemtoReg",  idx, 32'(wb_MemtoReg),  32'(v.e_wmtr));
        chk("wb_dst",       idx, 32'(wb_dst),       32'(v.e_wdst));
        chk("stall_cnt",    idx, 32'(stall_cnt),    32'(v.e_cnt));
    endtask

    initial begin
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_stall;
        vec_t             zero_v;

        total = 0;
        bad   = 0;

        //          rst ctl     rs rt rd fl  stl alu src dst exd  mrd mwr mdst  wrw wmtr wdst cnt
        tv[0]  = '{0, c_lw,   1, 5, 0, 0,  0,  0, 1, 0, 5,  0, 0, 0,  0, 0, 0,  0};  // LW r5
        tv[1]  = '{0, c_add,  5, 6, 8, 0,  1,  0, 0, 0, 0,  1, 0, 5,  0, 0, 0,  1};  // ADD uses r5: stall
        tv[2]  = '{0, c_add,  5, 6, 8, 0,  0,  2, 0, 1, 8,  0, 0, 0,  1, 1, 5,  1};
        tv[3]  = '{0, c_nop,  0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0, 8,  0, 0, 0,  1};
        tv[4]  = '{0, c_nop,  0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0, 0,  1, 0, 8,  1};
        tv[5]  = '{0, c_lw,   1, 0, 0, 0,  0,  0, 1, 0, 0,  0, 0, 0,  0, 0, 0,  1};  // LW r0
        tv[6]  = '{0, c_add,  0, 2, 3, 0,  0,  2, 0, 1, 3,  1, 0, 0,  0, 0, 0,  1};
        tv[7]  = '{0, c_nop,  0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0, 3,  0, 1, 0,  1};  // r0 write killed
        tv[8]  = '{0, c_nop,  0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0, 0,  1, 0, 3,  1};
        tv[9]  = '{0, c_lw,   1, 7, 0, 0,  0,  0, 1, 0, 7,  0, 0, 0,  0, 0, 0,  1};
        tv[10] = '{0, c_sw,   2, 7, 0, 0,  1,  0, 0, 0, 0,  1, 0, 7,  0, 0, 0,  2};  // SW data r7: stall
        tv[11] = '{0, c_sw,   2, 7, 0, 0,  0,  0, 1, 0, 7,  0, 0, 0,  1, 1, 7,  2};
        tv[12] = '{0, c_lw,   1, 7, 0, 0,  0,  0, 1, 0, 7,  0, 1, 7,  0, 0, 0,  2};
        tv[13] = '{0, c_addi, 2, 7, 0, 0,  0,  0, 1, 0, 7,  1, 0, 7,  0, 0, 7,  2};  // ADDI rt=7: no stall
        tv[14] = '{0, c_lw,   1, 5, 0, 0,  0,  0, 1, 0, 5,  0, 0, 7,  1, 1, 7,  2};
        tv[15] = '{0, c_add,  5, 6, 8, 1,  0,  0, 0, 0, 0,  1, 0, 5,  1, 0, 7,  2};  // flush beats hazard
        tv[16] = '{0, c_nop,  0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0, 0,  1, 1, 5,  2};
        tv[17] = '{0, c_sw,   2, 9, 0, 0,  0,  0, 1, 0, 9,  0, 0, 0,  0, 0, 0,  2};
        tv[18] = '{0, c_nop,  0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 1, 9,  0, 0, 0,  2};
        tv[19] = '{1, c_nop,  0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0};  // reset kills SW
        zero_v = '{0, c_nop,  0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0};

        // Reset state
        drive(1'b1, c_nop, 0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_regs(-1, zero_v);
        @(negedge clk);
        drive(1'b0, c_nop, 0, 0, 0, 1'b0);
        #1;
        chk("stall_o_reset", -1, 32'(stall_o), 32'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tv[i].rst, tv[i].ctl, tv[i].rs, tv[i].rt, tv[i].rd, tv[i].flush);
            #1;
            chk("stall_o", i, 32'(stall_o), 32'(tv[i].e_stall));
            @(posedge clk);
            #1;
            chk_regs(i, tv[i]);
        end

        // Back-to-back dependent loads: stall every other cycle, counter saturates
        exp_cnt = '0;
        for (int k = 0; k < 44; k++) begin
            @(negedge clk);
            drive(1'b0, c_lw, 5, 5, 0, 1'b0);
            exp_stall = (k % 2) == 1;
            #1;
            chk("sat_stall_o", k, 32'(stall_o), 32'(exp_stall));
            @(posedge clk);
            if (exp_stall && exp_cnt != 4'hF) exp_cnt = exp_cnt + 1'b1;
            #1;
            chk("sat_cnt", k, 32'(stall_cnt), 32'(exp_cnt));
        end
        chk("sat_final", 0, 32'(stall_cnt), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
